gp_reg_file: RTL and testbench

- General-purpose register file for the DECODE stage of the MIPS pipeline.
- 32 registers of 32 bits each.
- Two combinational read ports, A (addressed by rs) and B (addressed by rt), supply the operand values.
- One synchronous write port, addressed by rd, takes the WB-stage result.

---
 rtl/gp_reg_file.sv | 61 ++++++
 tb/tb_gp_reg_file.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gp_reg_file.sv
// Decode-stage general-purpose register file: two async read ports,
// one clocked write port, optional hardwired r0 and write bypass.
module gp_reg_file #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter bit ZERO_HARDWIRED = 1'b0,
  parameter bit WRITE_BYPASS   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_zero;
  logic              wr_en;
  logic              byp_a;
  logic              byp_b;
  logic              zero_a;
  logic              zero_b;

  assign rd_zero = (rd == '0);
  assign wr_en   = regwrite && !(ZERO_HARDWIRED && rd_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[rd] <= writedata;
    end
  end

  // Bypass is gated by rst_n so a held reset always reads zero.
  assign byp_a  = WRITE_BYPASS && rst_n && wr_en && (rd == rs);
  assign byp_b  = WRITE_BYPASS && rst_n && wr_en && (rd == rt);
  assign zero_a = ZERO_HARDWIRED && (rs == '0);
  assign zero_b = ZERO_HARDWIRED && (rt == '0);

  always_comb begin
    A = mem[rs];
    if (byp_a) A = writedata;
    if (zero_a) A = '0;
  end

  always_comb begin
    B = mem[rt];
    if (byp_b) B = writedata;
    if (zero_b) B = '0;
  end

endmodule

// File: tb/tb_gp_reg_file.sv
// Directed bench for gp_reg_file: default build plus a
// hardwired-r0 / bypass build driven from the same inputs.
module tb_gp_reg_file;

  logic        clk;
  logic        rst_n;
  logic        regwrite;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic [31:0] a0, b0, a1, b1;

  int total = 0;
  int bad   = 0;

  gp_reg_file dut0 (
    .clk(clk), .rst_n(rst_n), .regwrite(regwrite),
    .rs(rs), .rt(rt), .rd(rd), .writedata(writedata),
    .A(a0), .B(b0)
  );

  gp_reg_file #(
    .ZERO_HARDWIRED(1'b1),
    .WRITE_BYPASS(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .regwrite(regwrite),
    .rs(rs), .rt(rt), .rd(rd), .writedata(writedata),
    .A(a1), .B(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] ea;
    logic [31:0] eb;
  } rd_vec_t;

  rd_vec_t     vecs [5];
  logic [31:0] wdat [9];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] d);
    @(negedge clk);
    regwrite  = 1'b1;
    rd        = addr;
    writedata = d;
    @(posedge clk);
    #1;
    regwrite = 1'b0;
  endtask

  initial begin
    wdat[0] = 32'h002300AA; wdat[1] = 32'h10654321;
    wdat[2] = 32'h00100022; wdat[3] = 32'h8C123456;
    wdat[4] = 32'h8F123456; wdat[5] = 32'hAD654321;
    wdat[6] = 32'h13012345; wdat[7] = 32'hAC654321;
    wdat[8] = 32'h12012345;
    vecs[0] = '{5'd0, 5'd1, 32'h002300AA, 32'h10654321};
    vecs[1] = '{5'd2, 5'd3, 32'h00100022, 32'h8C123456};
    vecs[2] = '{5'd4, 5'd5, 32'h8F123456, 32'hAD654321};
    vecs[3] = '{5'd6, 5'd7, 32'h13012345, 32'hAC654321};
    vecs[4] = '{5'd8, 5'd8, 32'h12012345, 32'h12012345};

    rst_n = 1'b0; regwrite = 1'b0;
    rs = '0; rt = '0; rd = '0; writedata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // dirty some registers, then reset asynchronously
    wr(5'd3, 32'hA5A5A5A5);
    wr(5'd17, 32'h5A5A5A5A);
    wr(5'd31, 32'hFFFFFFFF);
    rs = 5'd31;
    #1;
    check("pre_reset_r31", a0, 32'hFFFFFFFF);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i);
      rt = 5'(31 - i);
      #1;
      check($sformatf("reset_a0_%0d", i), a0, 32'h0);
      check($sformatf("reset_b0_%0d", i), b0, 32'h0);
      check($sformatf("reset_a1_%0d", i), a1, 32'h0);
      check($sformatf("reset_b1_%0d", i), b1, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) wr(5'(i), wdat[i]);

    for (int i = 0; i < 5; i++) begin
      rs = vecs[i].rs;
      rt = vecs[i].rt;
      #1;
      check($sformatf("seq_a_%0d", i), a0, vecs[i].ea);
      check($sformatf("seq_b_%0d", i), b0, vecs[i].eb);
    end
    rs = 5'd0; rt = 5'd1;
    #1;
    check("hw0_r0", a1, 32'h0);
    check("hw0_r1", b1, 32'h10654321);

    // write disable
    @(negedge clk);
    regwrite = 1'b0; rd = 5'd3; writedata = 32'hFFFFFFFF; rs = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    check("wdis_dut0", a0, 32'h8C123456);
    check("wdis_dut1", a1, 32'h8C123456);

    // same-cycle read/write
    @(negedge clk);
    rs = 5'd5; rd = 5'd5; regwrite = 1'b1; writedata = 32'hDEADBEEF;
    #1;
    check("rw_pre_nobyp", a0, 32'hAD654321);
    check("rw_pre_byp", a1, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    #1;
    check("rw_post_dut0", a0, 32'hDEADBEEF);
    check("rw_post_dut1", a1, 32'hDEADBEEF);

    // register 0: ordinary in dut0, hardwired and never bypassed in dut1
    @(negedge clk);
    rs = 5'd0; rd = 5'd0; regwrite = 1'b1; writedata = 32'h12345678;
    #1;
    check("r0_nobyp", a1, 32'h0);
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    #1;
    check("r0_dut0", a0, 32'h12345678);
    check("r0_dut1", a1, 32'h0);
    wr(5'd1, 32'h0000BEEF);
    rs = 5'd1;
    #1;
    check("r1_dut1", a1, 32'h0000BEEF);

    // async reset with a write pending
    @(negedge clk);
    regwrite = 1'b1; rd = 5'd7; writedata = 32'h55555555;
    rs = 5'd7; rt = 5'd1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_a0", a0, 32'h0);
    check("mid_b0", b0, 32'h0);
    check("mid_a1", a1, 32'h0);
    check("mid_b1", b1, 32'h0);
    @(posedge clk);
    #1;
    check("mid_hold_a0", a0, 32'h0);
    check("mid_hold_a1", a1, 32'h0);
    @(negedge clk);
    regwrite = 1'b0;
    rst_n = 1'b1;
    #1;
    check("mid_rel_a0", a0, 32'h0);
    wr(5'd7, 32'h55555555);
    check("post_rst_wr", a0, 32'h55555555);
    check("post_rst_b", b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
